// File: rtl/keypad_code_collector_pkg.sv
// rtl/keypad_code_collector_pkg.sv - shared keypad key map and code-width parameters
package keypad_code_collector_pkg;

    localparam logic [3:0] KEY_BACKSPACE = 4'hA;
    localparam logic [3:0] KEY_CLEAR     = 4'hB;
    localparam logic [3:0] KEY_ENTER     = 4'hC;
    localparam int         CODE_DIGITS   = 4;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'h9;
    endfunction

endpackage

// File: rtl/entry_timeout_timer.sv
// rtl/entry_timeout_timer.sv - inactivity counter that flags a stale partial entry
module entry_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int              W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0]    LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // A restart on the expiry cycle suppresses the strobe: the key wins.
    assign expired = enable && !restart && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart || !enable || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/keypad_code_collector.sv
// rtl/keypad_code_collector.sv - assembles keypad digits into a 4-digit code with enter/backspace/clear/timeout
module keypad_code_collector #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] code_out,
    output logic        code_ready,
    output logic [2:0]  digit_count,
    output logic        entry_error,
    output logic        timeout
);

    import keypad_code_collector_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FULL,
        S_EMIT
    } state_t;

    localparam logic [2:0] FULL_COUNT = 3'(CODE_DIGITS);

    function automatic state_t state_for(input logic [2:0] n);
        if (n == 3'd0)       return S_IDLE;
        if (n == FULL_COUNT) return S_FULL;
        return S_COLLECT;
    endfunction

    state_t      state, state_n;
    logic [15:0] code_n;
    logic [2:0]  count_n;
    logic        ready_n, error_n, timeout_n;
    logic        key_live, restart, enable, expired;

    // Keys 0xD-0xF and anything arriving during EMIT never touch the timer.
    assign key_live = key_valid && (key_code <= KEY_ENTER) && (state != S_EMIT);
    assign restart  = key_live;
    assign enable   = (state == S_COLLECT) || (state == S_FULL);

    entry_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .enable (enable),
        .expired(expired)
    );

    always_comb begin
        state_n   = state;
        code_n    = code_out;
        count_n   = digit_count;
        ready_n   = 1'b0;
        error_n   = 1'b0;
        timeout_n = 1'b0;

        if (state == S_EMIT) begin
            state_n = S_IDLE;
            code_n  = '0;
            count_n = '0;
        end else if (key_live) begin
            if (is_digit(key_code)) begin
                if (digit_count == FULL_COUNT) begin
                    error_n = 1'b1;
                end else begin
                    code_n  = {code_out[11:0], key_code};
                    count_n = digit_count + 3'd1;
                end
            end else if (key_code == KEY_BACKSPACE) begin
                if (digit_count != 3'd0) begin
                    code_n  = {4'h0, code_out[15:4]};
                    count_n = digit_count - 3'd1;
                end
            end else if (key_code == KEY_CLEAR) begin
                code_n  = '0;
                count_n = '0;
            end else begin
                if (digit_count == FULL_COUNT) begin
                    ready_n = 1'b1;
                end else begin
                    error_n = 1'b1;
                    code_n  = '0;
                    count_n = '0;
                end
            end
            state_n = ready_n ? S_EMIT : state_for(count_n);
        end else if (expired) begin
            state_n   = S_IDLE;
            code_n    = '0;
            count_n   = '0;
            timeout_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            code_out    <= '0;
            digit_count <= '0;
            code_ready  <= 1'b0;
            entry_error <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            code_out    <= code_n;
            digit_count <= count_n;
            code_ready  <= ready_n;
            entry_error <= error_n;
            timeout     <= timeout_n;
        end
    end

endmodule

// File: tb/tb_keypad_code_collector.sv
// tb/tb_keypad_code_collector.sv - directed and random checks of keypad_code_collector against a digit-queue model
module tb_keypad_code_collector;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [15:0] code_out;
    logic        code_ready;
    logic [2:0]  digit_count;
    logic        entry_error;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    logic [3:0] m_digits[$];
    bit         m_emit;
    int         m_idle;
    bit         m_ready, m_err, m_to;

    keypad_code_collector #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .code_out   (code_out),
        .code_ready (code_ready),
        .digit_count(digit_count),
        .entry_error(entry_error),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_code();
        logic [15:0] v = 16'h0;
        foreach (m_digits[i]) v = {v[11:0], m_digits[i]};
        return v;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_emit = 0; m_idle = 0;
        m_ready = 0; m_err = 0; m_to = 0;
    endtask

    // Model of one clock edge: the digit list is the entry, idle counts cycles since the last key.
    task automatic model_edge(input bit v, input logic [3:0] k);
        m_ready = 0; m_err = 0; m_to = 0;
        if (m_emit) begin
            m_emit = 0;
            m_digits.delete();
        end else if (v && k <= 4'hC) begin
            m_idle = 0;
            if (k <= 4'h9) begin
                if (m_digits.size() == 4) m_err = 1;
                else m_digits.push_back(k);
            end else if (k == 4'hA) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
            end else if (k == 4'hB) begin
                m_digits.delete();
            end else begin
                if (m_digits.size() == 4) begin
                    m_emit = 1; m_ready = 1;
                end else begin
                    m_err = 1; m_digits.delete();
                end
            end
        end else if (m_digits.size() > 0) begin
            m_idle++;
            if (m_idle == T) begin
                m_to = 1; m_idle = 0; m_digits.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("code_out", code_out, m_code());
        chk("digit_count", {13'd0, digit_count}, 16'(m_digits.size()));
        chk("code_ready", {15'd0, code_ready}, {15'd0, m_ready});
        chk("entry_error", {15'd0, entry_error}, {15'd0, m_err});
        chk("timeout", {15'd0, timeout}, {15'd0, m_to});
    endtask

    task automatic step(input bit v, input logic [3:0] k);
        key_valid = v;
        key_code  = k;
        @(posedge clk);
        model_edge(v, k);
        #1;
        key_valid = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0);
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset_code", code_out, 16'h0000);
        chk("reset_count", {13'd0, digit_count}, 16'd0);
        chk("reset_strobes", {13'd0, code_ready, entry_error, timeout}, 16'd0);
        #10 rst_n = 1'b1;

        // enter 1234
        for (int d = 1; d <= 4; d++) begin
            step(1'b1, 4'(d));
            chk("t1_count", {13'd0, digit_count}, 16'(d));
        end
        step(1'b1, 4'hC);
        chk("t1_ready", {15'd0, code_ready}, 16'd1);
        chk("t1_code", code_out, 16'h1234);
        idle(1);
        chk("t1_after", code_out, 16'h0000);

        // backspace
        step(1'b1, 4'h5); step(1'b1, 4'h6); step(1'b1, 4'h7);
        chk("t2_0567", code_out, 16'h0567);
        step(1'b1, 4'hA);
        chk("t2_0056", code_out, 16'h0056);
        step(1'b1, 4'h8); step(1'b1, 4'h9); step(1'b1, 4'hC);
        chk("t2_5689", code_out, 16'h5689);
        chk("t2_ready", {15'd0, code_ready}, 16'd1);
        idle(1);

        // early enter, overflow digit
        step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'hC);
        chk("t3_err", {14'd0, entry_error, code_ready}, 16'b10);
        chk("t3_count", {13'd0, digit_count}, 16'd0);
        for (int d = 1; d <= 4; d++) step(1'b1, 4'(d));
        step(1'b1, 4'h7);
        chk("t3_ovf_err", {15'd0, entry_error}, 16'd1);
        chk("t3_ovf_code", code_out, 16'h1234);
        step(1'b1, 4'hB);

        // timeout exactly T cycles after acceptance
        step(1'b1, 4'h9);
        idle(T - 1);
        chk("t4_early", {15'd0, timeout}, 16'd0);
        idle(1);
        chk("t4_timeout", {15'd0, timeout}, 16'd1);
        chk("t4_count", {13'd0, digit_count}, 16'd0);
        step(1'b1, 4'h9);
        idle(T - 1);
        step(1'b1, 4'h1);
        chk("t4_keywins_to", {15'd0, timeout}, 16'd0);
        chk("t4_keywins_cnt", {13'd0, digit_count}, 16'd2);
        step(1'b1, 4'hB);

        // key during EMIT, ignored key does not restart timer
        for (int d = 1; d <= 4; d++) step(1'b1, 4'(d));
        step(1'b1, 4'hC);
        step(1'b1, 4'h3);
        chk("t5_drop_cnt", {13'd0, digit_count}, 16'd0);
        chk("t5_drop_code", code_out, 16'h0000);
        idle(1);
        step(1'b1, 4'h9);
        idle(3);
        step(1'b1, 4'hE);
        chk("t5_ignored", code_out, 16'h0009);
        idle(3);
        chk("t5_not_yet", {15'd0, timeout}, 16'd0);
        idle(1);
        chk("t5_timeout", {15'd0, timeout}, 16'd1);

        // asynchronous reset mid-entry
        step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'h3);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        step(1'b1, 4'h4); step(1'b1, 4'h3); step(1'b1, 4'h2); step(1'b1, 4'h1);
        step(1'b1, 4'hC);
        chk("t6_code", code_out, 16'h4321);
        chk("t6_ready", {15'd0, code_ready}, 16'd1);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 10) idle($urandom_range(1, T + 2));
            else step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
